// File: rtl/tag_lookup_sequencer_if.sv
// Lookup bus for the tag sequencer: request/response handshakes plus the tag-array and
// comparator side-band. The sequencer takes the slave modport.
interface tag_lookup_sequencer_if #(
  parameter int unsigned AddressSize = 32,
  parameter int unsigned TagBits     = 12,
  parameter int unsigned WayBits     = 3,
  parameter int unsigned CountBits   = 16
);
  logic                   reqValid;
  logic                   reqReady;
  logic [AddressSize-1:0] reqAddress;
  logic [WayBits-1:0]     waySel;
  logic [TagBits-1:0]     wayTag;
  logic                   wayValid;
  logic [TagBits-1:0]     cmpAddressTag;
  logic [TagBits-1:0]     cmpCacheTag;
  logic                   cmpMatch;
  logic                   respValid;
  logic                   respReady;
  logic                   respHit;
  logic [WayBits-1:0]     respWay;
  logic [AddressSize-1:0] respAddress;
  logic [CountBits-1:0]   hitCount;
  logic [CountBits-1:0]   missCount;

  modport slave (
    input  reqValid, reqAddress, wayTag, wayValid, cmpMatch, respReady,
    output reqReady, waySel, cmpAddressTag, cmpCacheTag, respValid, respHit, respWay,
           respAddress, hitCount, missCount
  );

  modport master (
    output reqValid, reqAddress, wayTag, wayValid, cmpMatch, respReady,
    input  reqReady, waySel, cmpAddressTag, cmpCacheTag, respValid, respHit, respWay,
           respAddress, hitCount, missCount
  );
endinterface

// File: rtl/tag_lookup_sequencer.sv
// Walks one shared tag comparator across the ways of a set, one way per cycle, and returns
// hit/miss with the first matching valid way. Keeps saturating hit/miss counters.
module tag_lookup_sequencer #(
  parameter int unsigned AddressSize = 32,
  parameter int unsigned TagBits     = 12,
  parameter int unsigned Ways        = 8,
  parameter int unsigned WayBits     = 3,
  parameter int unsigned CountBits   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tag_lookup_sequencer_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [WayBits-1:0] LastWay = WayBits'(Ways - 1);

  state_e                 state_q, state_d;
  logic [WayBits-1:0]     way_sel_q, way_sel_d;
  logic [AddressSize-1:0] addr_q, addr_d;
  logic                   resp_hit_q, resp_hit_d;
  logic [WayBits-1:0]     resp_way_q, resp_way_d;
  logic [CountBits-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CountBits-1:0]   miss_cnt_q, miss_cnt_d;
  logic                   way_hit;

  assign way_hit = bus_io.cmpMatch && bus_io.wayValid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      way_sel_q  <= '0;
      addr_q     <= '0;
      resp_hit_q <= 1'b0;
      resp_way_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      way_sel_q  <= way_sel_d;
      addr_q     <= addr_d;
      resp_hit_q <= resp_hit_d;
      resp_way_q <= resp_way_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    way_sel_d  = way_sel_q;
    addr_d     = addr_q;
    resp_hit_d = resp_hit_q;
    resp_way_d = resp_way_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.reqValid) begin
          addr_d    = bus_io.reqAddress;
          way_sel_d = '0;
          state_d   = StScan;
        end
      end
      StScan: begin
        // First hit ends the scan, so the lowest matching way wins.
        if (way_hit) begin
          resp_hit_d = 1'b1;
          resp_way_d = way_sel_q;
          state_d    = StDone;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
        end else if (way_sel_q == LastWay) begin
          resp_hit_d = 1'b0;
          resp_way_d = '0;
          state_d    = StDone;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        end else begin
          way_sel_d = way_sel_q + 1'b1;
        end
      end
      StDone: begin
        if (bus_io.respReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_io.reqReady      = (state_q == StIdle);
    bus_io.respValid     = (state_q == StDone);
    bus_io.waySel        = way_sel_q;
    bus_io.cmpAddressTag = addr_q[AddressSize-1 -: TagBits];
    bus_io.cmpCacheTag   = bus_io.wayTag;
    bus_io.respHit       = resp_hit_q;
    bus_io.respWay       = resp_way_q;
    bus_io.respAddress   = addr_q;
    bus_io.hitCount      = hit_cnt_q;
    bus_io.missCount     = miss_cnt_q;
  end

endmodule

// File: doc/tag_lookup_sequencer.md
Name: tag_lookup_sequencer

Overview:
- Sequences a single shared tag comparator across all ways of one set, one way per cycle, for a set-associative L2 lookup.
- Accepts one lookup request at a time and drives the way-select to the tag array.
- Drives the comparator's addressTag/cacheTag inputs and samples its match result.
- Returns a hit/miss response with the hitting way, and keeps saturating hit/miss statistics counters.

Parameters:
addressSize, 32, width of request address
tagBits, 12, tag width; tag = address[addressSize-1 -: tagBits]
ways, 8, associativity; power of two, >= 2
wayBits, 3, clog2(ways)
countBits, 16, width of hit/miss statistics counters

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
reqValid  input  1  lookup request present
reqReady  output  1  sequencer can accept request
reqAddress  input  addressSize  lookup address
waySel  output  wayBits  way index presented to tag array this cycle
wayTag  input  tagBits  tag of set[waySel], combinational same cycle
wayValid  input  1  valid bit of set[waySel], combinational same cycle
cmpAddressTag  output  tagBits  to comparator addressTag
cmpCacheTag  output  tagBits  to comparator cacheTag (= wayTag)
cmpMatch  input  1  comparator result, combinational same cycle
respValid  output  1  response available
respReady  input  1  consumer takes response
respHit  output  1  1 = hit, 0 = miss
respWay  output  wayBits  hitting way; 0 on miss
respAddress  output  addressSize  latched request address
hitCount  output  countBits  saturating hit counter
missCount  output  countBits  saturating miss counter

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. reqReady=1 after reset. All other outputs 0: respValid, respHit, respWay, respAddress, waySel, cmpAddressTag, hitCount, missCount.
- Reset mid-SCAN or mid-DONE aborts the lookup. No response is issued and counters clear.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - reqReady=1.
  - On an edge with reqValid=1: latch reqAddress, set cmpAddressTag = reqAddress tag field, set waySel=0, go to SCAN.
- SCAN:
  - reqReady=0. cmpCacheTag = wayTag (pass-through).
  - Hit condition sampled each edge: cmpMatch && wayValid.
  - On hit: respHit=1, respWay=waySel, go to DONE.
  - Else if waySel==ways-1: respHit=0, respWay=0, go to DONE.
  - Else: waySel increments by 1.
  - Invalid ways still consume a cycle.
  - Multiple matching ways: the lowest index wins, because scanning stops at the first hit.
- DONE:
  - respValid=1. respHit, respWay and respAddress stay stable until accepted.
  - On an edge with respReady=1: respValid=0, go to IDLE.
  - The request is not accepted in the same edge (reqReady=0 in DONE).
- Latency, measured from the accept edge:
  - Hit in way k: respValid high after edge k+1.
  - Miss: respValid high after edge `ways`.
  - Minimum turnaround between back-to-back requests: one IDLE cycle.
- Counters:
  - Increment on the SCAN->DONE transition: hitCount on hit, missCount on miss.
  - Saturate at 2^countBits-1, with no wrap.
- waySel holds its last value in DONE. It is don't-care for the tag array outside SCAN.
- reqAddress, wayTag and cmpMatch are ignored outside their sampling states.

Test Plan:
- ways=4, reqAddress=0xABC00000 (tag 0xABC), tags {0x111,0x222,0xABC,0x333} all valid, respReady=1 -> respValid after edge 3, respHit=1, respWay=2, hitCount=1.
- Same request, no way matches -> after edge 4: respHit=0, respWay=0, missCount=1. waySel observed sequence 0,1,2,3.
- Tag 0xABC in ways 1 and 3, way 1 valid=0 -> hit on way 3. Then ways 1 and 3 both valid -> respWay=1.
- Hold respReady=0 for 5 cycles after a hit -> respValid, respHit and respWay stay stable and reqReady=0. Assert respReady -> next cycle respValid=0, reqReady=1.
- Pulse rst_n=0 while waySel=2 in SCAN -> next cycle IDLE, reqReady=1, respValid=0, counters 0, and no response issued.
- countBits=2: issue 5 misses -> missCount saturates at 3 and hitCount stays 0.
